// File: rtl/bcp_pkg.sv
// -----------------------------------------------------------------------------
// bcp_pkg
// Shared types and constants for the Boolean-constraint-propagation processing
// element.
//   LIT_W   : literal width, two's complement, 0 marks an empty clause slot
//   CLA_LEN : literals per clause; slot i lives at [i*LIT_W +: LIT_W]
//   lit_t   : one signed literal
//   cla_t   : one packed clause
//   state_t : PE control states {LOAD, RUN, HALT}
//   lit_neg : complement of a literal
// -----------------------------------------------------------------------------
package bcp_pkg;

  localparam int LIT_W   = 8;
  localparam int CLA_LEN = 3;

  typedef logic signed [LIT_W-1:0]         lit_t;
  typedef logic        [CLA_LEN*LIT_W-1:0] cla_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Complement of a literal; legal literals never hit the most negative code,
  // so the negation cannot overflow.
  function automatic lit_t lit_neg(input lit_t l);
    return -l;
  endfunction

endpackage

// File: rtl/bcp_lit_eval.sv
// -----------------------------------------------------------------------------
// bcp_lit_eval
// Combinational evaluation of one clause against the loaded unit literals.
// Ports:
//   i_clause   : clause under evaluation
//   i_slots    : unit literal slots
//   i_slotMask : which slots currently hold a loaded literal
//   o_sat      : some clause literal equals a unit literal
//   o_pruned   : clause with literals contradicted by a unit literal zeroed
//   o_nzMask   : per-slot flag, pruned literal still nonzero
// -----------------------------------------------------------------------------
module bcp_lit_eval
  import bcp_pkg::*;
#(
  parameter int NUM_UC = 2
) (
  input  cla_t                     i_clause,
  input  lit_t [NUM_UC-1:0]        i_slots,
  input  logic [NUM_UC-1:0]        i_slotMask,
  output logic                     o_sat,
  output cla_t                     o_pruned,
  output logic [CLA_LEN-1:0]       o_nzMask
);

  lit_t w_lit;

  // Every clause literal is compared against every live unit literal. A match
  // satisfies the whole clause; a complement match removes just that literal.
  // Empty slots (zero) never match because live unit literals are nonzero.
  always_comb begin
    o_sat    = 1'b0;
    o_pruned = i_clause;
    o_nzMask = '0;
    w_lit    = '0;
    for (int i = 0; i < CLA_LEN; i++) begin
      w_lit = i_clause[i*LIT_W +: LIT_W];
      for (int j = 0; j < NUM_UC; j++) begin
        if (i_slotMask[j] && (i_slots[j] != '0)) begin
          if (w_lit == i_slots[j]) begin
            o_sat = 1'b1;
          end else if (w_lit == lit_neg(i_slots[j])) begin
            o_pruned[i*LIT_W +: LIT_W] = '0;
          end
        end
      end
      o_nzMask[i] = (o_pruned[i*LIT_W +: LIT_W] != '0);
    end
  end

endmodule

// File: rtl/bcp_pe_pipe.sv
// -----------------------------------------------------------------------------
// bcp_pe_pipe
// Handshaked Boolean-constraint-propagation processing element. A pass loads
// up to NUM_UC unit literals from the unit-clause queue, then streams clauses
// from the clause queue: satisfied clauses are dropped, unit results become
// implications, longer results are forwarded pruned, and an emptied clause
// raises a sticky conflict. An all-zero clause ends the pass and is forwarded
// as a delimiter.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   uc_valid/uc_lit/uc_pop   : unit-clause queue head and pop
//   cl_valid/cl_data/cl_pop  : clause queue head and pop
//   out_valid/out_clause/out_delim/out_ready : forwarded clause / delimiter
//   imp_valid/imp_lit/imp_ready              : implied literal
//   conflict, conflict_clr   : sticky conflict flag and its clear (HALT only)
//   busy                     : anything other than idle LOAD with no slots
// Optional build macro BCP_PE_STATS_EN adds stat_sat/stat_imp/stat_fwd,
// 16-bit saturating counters cleared on reset and on every entry to LOAD.
// -----------------------------------------------------------------------------
module bcp_pe_pipe
  import bcp_pkg::*;
#(
  parameter int NUM_UC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     uc_valid,
  input  logic [LIT_W-1:0]         uc_lit,
  output logic                     uc_pop,
  input  logic                     cl_valid,
  input  logic [CLA_LEN*LIT_W-1:0] cl_data,
  output logic                     cl_pop,
  output logic                     out_valid,
  output logic [CLA_LEN*LIT_W-1:0] out_clause,
  output logic                     out_delim,
  input  logic                     out_ready,
  output logic                     imp_valid,
  output logic [LIT_W-1:0]         imp_lit,
  input  logic                     imp_ready,
  output logic                     conflict,
  input  logic                     conflict_clr,
  output logic                     busy
`ifdef BCP_PE_STATS_EN
  ,
  output logic [15:0]              stat_sat,
  output logic [15:0]              stat_imp,
  output logic [15:0]              stat_fwd
`endif
);

  localparam int CNT_W = $clog2(NUM_UC + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_slotCnt;
  lit_t [NUM_UC-1:0]  r_slot;
  logic               r_conflict;

  // Output register R, shared by the forward and implication channels.
  logic               r_outValid;
  cla_t               r_outClause;
  logic               r_outDelim;
  logic               r_impValid;
  lit_t               r_impLit;

  logic [NUM_UC-1:0]  w_slotMask;
  logic               w_ucClash;
  logic               w_rFree;
  logic               w_isDelim;
  logic               w_sat;
  cla_t               w_pruned;
  logic [CLA_LEN-1:0] w_nzMask;
  logic               w_nzNone;
  logic               w_nzOne;
  lit_t               w_unitLit;

  bcp_lit_eval #(
    .NUM_UC (NUM_UC)
  ) u_eval (
    .i_clause   (cl_data),
    .i_slots    (r_slot),
    .i_slotMask (w_slotMask),
    .o_sat      (w_sat),
    .o_pruned   (w_pruned),
    .o_nzMask   (w_nzMask)
  );

  // Slot j is live once the load counter has moved past it. The clash check
  // compares the incoming unit literal with the complement of each live slot,
  // which catches an l / -l pair as soon as the second one is popped.
  always_comb begin
    w_slotMask = '0;
    w_ucClash  = 1'b0;
    for (int j = 0; j < NUM_UC; j++) begin
      w_slotMask[j] = (CNT_W'(j) < r_slotCnt);
      if (w_slotMask[j] && (uc_lit == lit_neg(r_slot[j]))) begin
        w_ucClash = 1'b1;
      end
    end
  end

  // With exactly one literal left, all other pruned slots are zero, so
  // OR-ing every slot yields the surviving literal without a priority mux.
  always_comb begin
    w_unitLit = '0;
    for (int i = 0; i < CLA_LEN; i++) begin
      w_unitLit = w_unitLit | w_pruned[i*LIT_W +: LIT_W];
    end
  end

  assign w_isDelim = (cl_data == '0);
  assign w_nzNone  = (w_nzMask == '0);
  assign w_nzOne   = $onehot(w_nzMask);

  // R accepts a new clause result when each pending channel is draining now.
  assign w_rFree = (!r_outValid || out_ready) && (!r_impValid || imp_ready);

  // Pops are gated by reset so a reset cycle never consumes a queue entry.
  // LOAD and RUN are exclusive, so both pops can never assert together.
  assign uc_pop = rst_n && (r_state == LOAD) && uc_valid
                  && (r_slotCnt < CNT_W'(NUM_UC));
  assign cl_pop = rst_n && (r_state == RUN) && cl_valid && w_rFree;

  assign out_valid  = r_outValid;
  assign out_clause = r_outClause;
  assign out_delim  = r_outDelim;
  assign imp_valid  = r_impValid;
  assign imp_lit    = r_impLit;
  assign conflict   = r_conflict;
  assign busy       = !((r_state == LOAD) && (r_slotCnt == '0));

  // Main control: slot loading, clause classification into R, conflict and
  // pass delimiting. R drains first each cycle; a clause popped in the same
  // cycle then overwrites the drained entry, keeping one clause per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_slotCnt   <= '0;
      r_slot      <= '0;
      r_conflict  <= 1'b0;
      r_outValid  <= 1'b0;
      r_outClause <= '0;
      r_outDelim  <= 1'b0;
      r_impValid  <= 1'b0;
      r_impLit    <= '0;
    end else begin
      if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
        r_outDelim <= 1'b0;
      end
      if (r_impValid && imp_ready) begin
        r_impValid <= 1'b0;
      end

      case (r_state)
        LOAD: begin
          if (uc_pop) begin
            for (int j = 0; j < NUM_UC; j++) begin
              if (CNT_W'(j) == r_slotCnt) begin
                r_slot[j] <= uc_lit;
              end
            end
            r_slotCnt <= r_slotCnt + CNT_W'(1);
            if (w_ucClash) begin
              r_conflict <= 1'b1;
              r_state    <= HALT;
            end else if (r_slotCnt == CNT_W'(NUM_UC - 1)) begin
              r_state <= RUN;
            end
          end else if ((r_slotCnt == CNT_W'(NUM_UC)) ||
                       (!uc_valid && (r_slotCnt != '0))) begin
            r_state <= RUN;
          end
        end

        RUN: begin
          if (cl_pop) begin
            if (w_isDelim) begin
              r_outValid  <= 1'b1;
              r_outDelim  <= 1'b1;
              r_outClause <= '0;
              r_slot      <= '0;
              r_slotCnt   <= '0;
              r_state     <= LOAD;
            end else if (w_sat) begin
              r_state <= RUN;
            end else if (w_nzNone) begin
              r_conflict <= 1'b1;
              r_state    <= HALT;
            end else if (w_nzOne) begin
              r_impValid <= 1'b1;
              r_impLit   <= w_unitLit;
            end else begin
              r_outValid  <= 1'b1;
              r_outDelim  <= 1'b0;
              r_outClause <= w_pruned;
            end
          end
        end

        HALT: begin
          if (conflict_clr) begin
            r_conflict <= 1'b0;
            r_slot     <= '0;
            r_slotCnt  <= '0;
            r_state    <= LOAD;
          end
        end

        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

`ifdef BCP_PE_STATS_EN
  logic        w_enterLoad;
  logic        w_cntSat;
  logic        w_cntImp;
  logic        w_cntFwd;
  logic [15:0] r_statSat;
  logic [15:0] r_statImp;
  logic [15:0] r_statFwd;

  assign w_enterLoad = (cl_pop && w_isDelim) || ((r_state == HALT) && conflict_clr);
  assign w_cntSat    = cl_pop && !w_isDelim && w_sat;
  assign w_cntImp    = cl_pop && !w_isDelim && !w_sat && w_nzOne;
  assign w_cntFwd    = cl_pop && !w_isDelim && !w_sat && !w_nzNone && !w_nzOne;

  assign stat_sat = r_statSat;
  assign stat_imp = r_statImp;
  assign stat_fwd = r_statFwd;

  // Per-pass statistics: each counter sticks at all-ones instead of wrapping
  // and restarts whenever a new pass begins.
  always_ff @(posedge clk) begin
    if (!rst_n || w_enterLoad) begin
      r_statSat <= '0;
      r_statImp <= '0;
      r_statFwd <= '0;
    end else begin
      if (w_cntSat && (r_statSat != 16'hFFFF)) r_statSat <= r_statSat + 16'd1;
      if (w_cntImp && (r_statImp != 16'hFFFF)) r_statImp <= r_statImp + 16'd1;
      if (w_cntFwd && (r_statFwd != 16'hFFFF)) r_statFwd <= r_statFwd + 16'd1;
    end
  end
`endif

endmodule

// File: doc/bcp_pe_pipe.md
Name: bcp_pe_pipe

Overview:
- Parametrised, handshaked Boolean-constraint-propagation processing element.
- Holds up to NUM_UC unit literals per pass and streams clauses from the clause queue.
- Per clause it prunes false literals, drops satisfied clauses, emits implications for unit results and flags conflicts.
- Sits between the unit-clause queue (UCQ), the clause queue (CLQ) and the next engine's input queue; an all-zero clause delimits passes.

Parameters:
- CLA_LEN, 3, literals per clause.
- LIT_W, 8, literal width; two's complement; 0 = empty slot; legal range ±(2^(LIT_W-1)-1).
- NUM_UC, 2, unit literals applied concurrently per pass.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- uc_valid  in  1  UCQ non-empty
- uc_lit  in  LIT_W  UCQ head literal
- uc_pop  out  1  pop UCQ head this cycle
- cl_valid  in  1  CLQ non-empty
- cl_data  in  CLA_LEN*LIT_W  CLQ head clause; slot i at [i*LIT_W +: LIT_W]
- cl_pop  out  1  pop CLQ head this cycle
- out_valid  out  1  pruned clause / delimiter valid
- out_clause  out  CLA_LEN*LIT_W  pruned clause
- out_delim  out  1  out_clause is a pass delimiter
- out_ready  in  1  next engine queue not full
- imp_valid  out  1  implication valid
- imp_lit  out  LIT_W  implied literal
- imp_ready  in  1  UCQ input not full
- conflict  out  1  sticky conflict flag
- conflict_clr  in  1  clear conflict; return to LOAD
- busy  out  1  FSM not in LOAD with zero slots filled

Behaviour:
- Reset: FSM=LOAD; slots and slot count cleared; all outputs 0.
- LOAD state:
  - uc_pop = uc_valid while the slot count < NUM_UC; the popped literal enters the next slot.
  - Go to RUN when slots are full, or when uc_valid=0 with at least one slot filled. With zero slots, wait.
  - If two loaded slots hold l and -l: set conflict, go to HALT.
- RUN state: a one-deep output register R feeds both out and imp.
  - R is free when neither of its valids is pending, or each pending valid sees its ready.
  - cl_pop = cl_valid & R free. The popped clause is evaluated combinationally and R is loaded in the same cycle, giving 1-cycle latency.
- Per-literal evaluation, slot i, against all nonzero slot literals u:
  - lit == u: clause satisfied.
  - lit == -u: pruned to 0.
  - Otherwise unchanged.
- Clause classification and result:
  - Satisfied: nothing emitted; the pop still occurs.
  - Exactly one nonzero remains: imp_valid=1, imp_lit = that literal; clause not forwarded.
  - Two or more nonzero remain: out_valid=1 with the pruned clause.
  - Zero remain and not satisfied (original clause nonzero): conflict=1, go to HALT; nothing emitted.
- Delimiter handling:
  - An all-zero cl_data is forwarded with out_delim=1 and out_valid=1.
  - Slots are cleared and the FSM returns to LOAD the cycle after it is accepted into R.
- HALT state: cl_pop=0 and uc_pop=0. Already-registered R outputs still drain.
  - conflict_clr clears conflict and the slots, then goes to LOAD.
  - conflict_clr has no effect outside HALT.
- Simultaneity:
  - A pop and an R drain in the same cycle are legal (full throughput: 1 clause/cycle).
  - cl_pop and uc_pop are never both asserted.
- Synchronous reset mid-pass discards R contents and slots; no partial pop is issued.

Optional Feature:
- BCP_PE_STATS_EN defined: adds output ports stat_sat, stat_imp, stat_fwd, 16 bits each.
  - Saturating counters of satisfied, implied and forwarded clauses.
  - Cleared on reset and when the FSM enters LOAD.
- Undefined: no ports and no counters.

Decomposition:
- Package bcp_pkg: LIT_W, CLA_LEN, lit_t, cla_t and the FSM state enum {LOAD, RUN, HALT}.
- Sub-module bcp_lit_eval: combinational evaluation of one clause against the slot array. Outputs sat, pruned clause, nonzero mask.
- Parent bcp_pe_pipe: owns the FSM, slots, output register R and stats.

Test Plan:
- UCQ {3}, clause (3,-5,7) -> no output, cl_pop pulse, imp_valid=0, out_valid=0.
- UCQ {-3}, clause (3,-5,0) -> imp_valid=1, imp_lit=-5 one cycle after pop.
- UCQ {2,4}, clause (-2,-4,6) -> imp_lit=6. Then clause (-2,1,6) -> out_clause=(0,1,6).
- UCQ {5}, clause (-5,0,0) -> conflict=1, HALT, cl_pop held 0. conflict_clr -> LOAD, conflict=0.
- UCQ {3,-3} -> conflict during LOAD, no clause popped.
- Back-to-back forwarded clauses with out_ready low 3 cycles -> R held, cl_pop=0 for those cycles. Delimiter then forwarded with out_delim=1, after which uc_pop is asserted.
